// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, baud width and TX FSM states.
// Imported by the transmitter, its bit timer and (later) the receiver.
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int BAUD_W     = 13;
    localparam int BAUD_MIN   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XMIT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter with a one-cycle expire strobe.
// Expires while counting at 1, so a load of N gives an N-clock period.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [BAUD_W-1:0] load_val,
    output logic              expire
);

    logic [BAUD_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= cnt_q - BAUD_W'(1);
        end
    end

    assign expire = en && (cnt_q == BAUD_W'(1));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with runtime bit period and a one-byte holding
// register so consecutive frames can run with no idle gap.
module uart_tx
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trmt,
    input  logic [7:0]        tx_data,
    input  logic [BAUD_W-1:0] baud,
    input  logic              clr_done,
    output logic              TX,
    output logic              tx_rdy,
    output logic              tx_done,
    output logic              ovr
);

    tx_state_t             state_q, state_n;
    logic [FRAME_BITS-1:0] shift_q, shift_n;
    logic [3:0]            bit_cnt_q, bit_cnt_n;
    logic [7:0]            hold_q, hold_n;
    logic                  hold_full_q, hold_full_n;
    logic [BAUD_W-1:0]     baud_q, baud_n;
    logic [BAUD_W-1:0]     baud_clamp, load_val;
    logic                  done_q, done_n;
    logic                  ovr_q, ovr_n;
    logic                  tx_q;
    logic                  start, expire, frame_end;

    assign baud_clamp = (baud < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN) : baud;
    assign frame_end  = expire && (bit_cnt_q == 4'(FRAME_BITS - 1));
    assign load_val   = start ? baud_clamp : baud_q;

    uart_bit_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start | expire),
        .en       (state_q == XMIT),
        .load_val (load_val),
        .expire   (expire)
    );

    always_comb begin
        state_n     = state_q;
        shift_n     = shift_q;
        bit_cnt_n   = bit_cnt_q;
        hold_n      = hold_q;
        hold_full_n = hold_full_q;
        baud_n      = baud_q;
        done_n      = done_q;
        ovr_n       = ovr_q;
        start       = 1'b0;

        // Sets below are applied after this clear, so a set wins.
        if (clr_done) begin
            done_n = 1'b0;
            ovr_n  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (trmt) begin
                    start     = 1'b1;
                    shift_n   = {1'b1, tx_data, 1'b0};
                    bit_cnt_n = '0;
                    baud_n    = baud_clamp;
                    done_n    = 1'b0;
                    state_n   = XMIT;
                end
            end
            XMIT: begin
                if (trmt && !frame_end) begin
                    if (hold_full_q) begin
                        ovr_n = 1'b1;
                    end else begin
                        hold_n      = tx_data;
                        hold_full_n = 1'b1;
                    end
                end
                if (expire) begin
                    shift_n   = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_n = bit_cnt_q + 4'd1;
                end
                if (frame_end) begin
                    unique case (1'b1)
                        hold_full_q: begin
                            start       = 1'b1;
                            shift_n     = {1'b1, hold_q, 1'b0};
                            bit_cnt_n   = '0;
                            baud_n      = baud_clamp;
                            hold_full_n = 1'b0;
                            if (trmt) ovr_n = 1'b1;
                        end
                        (!hold_full_q && trmt): begin
                            start     = 1'b1;
                            shift_n   = {1'b1, tx_data, 1'b0};
                            bit_cnt_n = '0;
                            baud_n    = baud_clamp;
                            done_n    = 1'b0;
                        end
                        default: begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '1;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            baud_q      <= BAUD_W'(BAUD_MIN);
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_n;
            shift_q     <= shift_n;
            bit_cnt_q   <= bit_cnt_n;
            hold_q      <= hold_n;
            hold_full_q <= hold_full_n;
            baud_q      <= baud_n;
            done_q      <= done_n;
            ovr_q       <= ovr_n;
            tx_q        <= shift_n[0];
        end
    end

    assign TX      = tx_q;
    assign tx_rdy  = !hold_full_q;
    assign tx_done = done_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus queues expected frames,
// a line monitor decodes TX and checks every bit period.
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         per;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trmt;
    logic [7:0]        tx_data;
    logic [BAUD_W-1:0] baud;
    logic              clr_done;
    logic              TX, tx_rdy, tx_done, ovr;

    int     cyc = 0;
    int     checks = 0;
    int     passes = 0;
    frame_t exp_q[$];
    int     starts[$];
    logic   prev_tx = 1'b1;

    uart_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .baud     (baud),
        .clr_done (clr_done),
        .TX       (TX),
        .tx_rdy   (tx_rdy),
        .tx_done  (tx_done),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) sync();
    endtask

    // Called just after a posedge; byte is accepted on the next edge.
    task automatic send(input logic [7:0] b, output int acc);
        trmt    = 1'b1;
        tx_data = b;
        sync();
        acc  = cyc;
        trmt = 1'b0;
    endtask

    task automatic clr();
        clr_done = 1'b1;
        sync();
        clr_done = 1'b0;
    endtask

    task automatic wait_done(input int acc, input int len, input string nm);
        int i = 0;
        while (!tx_done && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (!tx_done) chk(nm, -1, len);
        else chk(nm, cyc - acc, len);
    endtask

    function automatic int gap(input int i, input int j);
        if (starts.size() > j) return starts[j] - starts[i];
        return -1;
    endfunction

    // Line monitor: on each start bit pop the expected frame and check
    // all 10*per samples; a reset during the frame discards it.
    initial begin : monitor
        frame_t e;
        logic   ok, abort, expb;
        int     bad;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tx = 1'b1;
            end else if (prev_tx && !TX) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got start bit want idle (cyc %0d)", cyc);
                    prev_tx = TX;
                end else begin
                    e = exp_q.pop_front();
                    starts.push_back(cyc);
                    ok = 1'b1;
                    abort = 1'b0;
                    bad = -1;
                    for (int n = 0; n < FRAME_BITS * e.per && !abort; n++) begin
                        int b;
                        if (n != 0) @(negedge clk);
                        b = n / e.per;
                        if (!rst_n) begin
                            abort = 1'b1;
                        end else begin
                            if (b == 0) expb = 1'b0;
                            else if (b == FRAME_BITS - 1) expb = 1'b1;
                            else expb = e.data[b-1];
                            if (TX !== expb && ok) begin
                                ok = 1'b0;
                                bad = b;
                            end
                        end
                    end
                    prev_tx = TX;
                    if (!abort) begin
                        checks++;
                        if (ok) passes++;
                        else $display("FAIL frame_%h: got wrong level at bit %0d want per=%0d clean frame",
                                      e.data, bad, e.per);
                    end
                end
            end else begin
                prev_tx = TX;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int a0, a1;
        rst_n    = 1'b0;
        trmt     = 1'b0;
        tx_data  = 8'h00;
        baud     = 13'd16;
        clr_done = 1'b0;
        repeat (3) sync();
        chk("rst_tx", TX, 1);
        chk("rst_rdy", tx_rdy, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        sync();

        // single frame
        starts.delete();
        exp_q.push_back('{8'hA5, 16});
        send(8'hA5, a0);
        chk("idle_rdy", tx_rdy, 1);
        wait_done(a0, 160, "single_done");
        chk("single_lat", starts.size() > 0 ? starts[0] - a0 : -1, 0);
        chk("single_idle_tx", TX, 1);
        sync();

        // back-to-back through the holding register
        clr();
        starts.delete();
        exp_q.push_back('{8'h3C, 16});
        exp_q.push_back('{8'hC3, 16});
        send(8'h3C, a0);
        to_cyc(a0 + 19);
        send(8'hC3, a1);
        chk("b2b_rdy0", tx_rdy, 0);
        to_cyc(a0 + 159);
        chk("b2b_rdy_hold", tx_rdy, 0);
        to_cyc(a0 + 160);
        chk("b2b_rdy1", tx_rdy, 1);
        chk("b2b_mid_done", tx_done, 0);
        wait_done(a0, 320, "b2b_done");
        chk("b2b_gap", gap(0, 1), 160);
        sync();

        // overrun
        clr();
        exp_q.push_back('{8'h55, 16});
        exp_q.push_back('{8'h0F, 16});
        send(8'h55, a0);
        to_cyc(a0 + 4);
        send(8'h0F, a1);
        to_cyc(a0 + 9);
        send(8'hFF, a1);
        @(negedge clk);
        chk("ovr_set", ovr, 1);
        chk("ovr_rdy", tx_rdy, 0);
        wait_done(a0, 320, "ovr_done");
        sync();
        chk("ovr_sticky", ovr, 1);
        clr();
        chk("ovr_clr", ovr, 0);
        chk("done_clr", tx_done, 0);

        // baud change mid-frame
        baud = 13'd20;
        exp_q.push_back('{8'h81, 20});
        send(8'h81, a0);
        to_cyc(a0 + 50);
        baud = 13'd8;
        wait_done(a0, 200, "baud_old");
        sync();
        exp_q.push_back('{8'h7E, 8});
        send(8'h7E, a1);
        wait_done(a1, 80, "baud_new");
        sync();

        // reset mid-frame
        baud = 13'd16;
        exp_q.push_back('{8'h00, 16});
        send(8'h00, a0);
        to_cyc(a0 + 37);
        #1 rst_n = 1'b0;
        #1;
        chk("rstm_tx", TX, 1);
        chk("rstm_rdy", tx_rdy, 1);
        chk("rstm_done", tx_done, 0);
        chk("rstm_ovr", ovr, 0);
        sync();
        sync();
        rst_n = 1'b1;
        sync();
        starts.delete();
        exp_q.push_back('{8'h24, 16});
        send(8'h24, a1);
        wait_done(a1, 160, "rstm_after");
        chk("rstm_lat", starts.size() > 0 ? starts[0] - a1 : -1, 0);
        sync();

        // clamp and stop-bit collision
        baud = 13'd0;
        clr();
        starts.delete();
        exp_q.push_back('{8'h5A, 2});
        exp_q.push_back('{8'hA6, 2});
        send(8'h5A, a0);
        to_cyc(a0 + 19);
        send(8'hA6, a1);
        @(negedge clk);
        chk("coll_done0", tx_done, 0);
        wait_done(a0, 40, "coll_done");
        chk("coll_gap", gap(0, 1), 20);

        repeat (30) sync();
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter that pairs with the UART receiver: 8N1 framing, LSB first, with a runtime-programmable bit period. It accepts bytes from a local host over a trmt/tx_rdy handshake. A one-entry holding register allows back-to-back frames with no idle gap. It sits between the host command logic and the TX pad.

Parameters:
BAUD_W, 13, width of the baud port and the bit-period counter
FRAME_BITS, 10, bits per frame (start + 8 data + stop); fixed, not overridable

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
trmt  in  1  single-cycle request to send tx_data
tx_data  in  8  byte to send; sampled on the cycle trmt is accepted
baud  in  BAUD_W  clocks per bit; sampled at each frame start
clr_done  in  1  clears tx_done and ovr
TX  out  1  serial line, idle high; register output
tx_rdy  out  1  1 = holding register empty, so trmt will be accepted
tx_done  out  1  sticky: last frame finished and no frame is pending
ovr  out  1  sticky: a trmt was dropped while tx_rdy=0

Behaviour:
- Reset values: TX=1, tx_rdy=1, tx_done=0, ovr=0, state=IDLE, holding register empty. Reset asserted mid-frame forces TX=1 asynchronously and discards both the active frame and the held byte.
- State machine:
  - IDLE: on trmt, load shift register {1'b1, tx_data, 1'b0}, bit_cnt=0, baud_q=baud, go to XMIT.
  - XMIT: on each bit-period expiry, shift right with 1 fill and increment bit_cnt.
  - When bit_cnt reaches 10, the frame ends:
    - hold full: load the held byte as a new frame in the same cycle; TX goes from stop bit directly to start bit, with no idle cycles; stay in XMIT.
    - hold empty: go to IDLE and set tx_done.
- Latency: trmt accepted in cycle N, so TX=0 (start bit) from the clock edge ending cycle N. Each bit is exactly baud_q clocks. A frame is 10*baud_q clocks. tx_done rises on the edge where the stop bit completes.
- TX is a flop driven from shift_reg[0], so it is glitch-free.
- Baud counter:
  - Down-counter loaded with baud_q at frame start and at each shift.
  - It expires at count 1.
  - baud values 0 and 1 are clamped to 2.
  - A change on baud mid-frame has no effect until the next frame start.
- Handshake:
  - trmt in XMIT with hold empty: byte captured into hold, tx_rdy=0 the next cycle.
  - trmt in XMIT with hold full: byte dropped, ovr set, active frame and held byte unaffected.
  - tx_rdy returns to 1 on the cycle the held byte is moved into the shift register.
  - trmt in IDLE always starts a frame; tx_rdy stays 1.
- tx_done:
  - Cleared when a frame is accepted from IDLE, or by clr_done.
  - If a set and clr_done occur in the same cycle, set wins.
- ovr: cleared only by clr_done; set wins over a simultaneous clr_done.
- trmt on the exact cycle a frame ends with hold empty:
  - The new byte starts immediately as the next frame, with no gap.
  - tx_done is not set.
  - This counts as IDLE acceptance.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, XMIT}
  - localparam FRAME_BITS=10
  - localparam BAUD_W=13
  - localparam BAUD_MIN=2
  - The receiver shares FRAME_BITS and BAUD_W from this package.
- Sub-module uart_bit_timer: loadable BAUD_W down-counter with load/enable inputs and a one-cycle expire pulse. The receiver can reuse it later.
- Shift register, holding register and FSM stay in uart_tx.

Test Plan:
- Single frame: baud=16, trmt with tx_data=8'hA5 → TX sequence 0,1,0,1,0,0,1,0,1,1, each exactly 16 clk; tx_done rises 160 clk after TX falls; TX=1 afterwards.
- Back-to-back: baud=16; send 8'h3C, then trmt 8'hC3 at clk 20 → tx_rdy=0 from clk 21; second start bit begins at clk 160 with no idle cycle; tx_done rises only at clk 320.
- Overrun: baud=16, while a frame is active and hold is full, send trmt 8'hFF → ovr=1, TX stream unchanged; clr_done → ovr=0, tx_done=0.
- Baud change mid-frame: start frame with baud=20, change baud to 8 at clk 50 → the frame still lasts 200 clk; the next frame uses 8 clk/bit.
- Reset mid-frame: assert rst_n low at clk 37 of an 8'h00 frame → TX=1 immediately, tx_rdy=1, tx_done=0; after release a trmt starts a clean frame.
- Clamp and collision: baud=0 gives 2 clk/bit (frame 20 clk); trmt on the stop-bit end cycle → next start bit with no gap and tx_done stays 0.
